// File: rtl/grant_request_sequencer.sv
// grant_request_sequencer
// Turns a requester's req/done level handshake and a resource-ready level
// into the four single-cycle transition pulses of the downstream
// IDLE/REQUESTING/GRANT/REVOKE arbitration FSM. It also enforces a maximum
// grant length, counted only while i_granted is high, and a post-revoke
// cooldown.
// Optional feature: define GRANT_REQ_SEQ_STATS_EN to add saturating grant
// and forced-revoke statistics counters with a synchronous clear.
module grant_request_sequencer #(
  parameter int MAX_GRANT_CYCLES = 16,
  parameter int COOLDOWN_CYCLES  = 2,
  parameter int STAT_W           = 16
) (
  input  logic              i_ck,
  input  logic              i_arst,
  input  logic              i_req,
  input  logic              i_ready,
  input  logic              i_done,
  input  logic              i_granted,
`ifdef GRANT_REQ_SEQ_STATS_EN
  input  logic              i_statClr,
  output logic [STAT_W-1:0] o_grantCount,
  output logic [STAT_W-1:0] o_forcedCount,
`endif
  output logic              o_stateTransition1,
  output logic              o_stateTransition2,
  output logic              o_stateTransition3,
  output logic              o_stateTransition4,
  output logic              o_forcedRevoke,
  output logic              o_busy
);

  localparam int HCW = $clog2(MAX_GRANT_CYCLES + 1);
  localparam int CCW = (COOLDOWN_CYCLES < 1) ? 1 : $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_GRANT_CYCLES - 1);
  localparam logic [CCW-1:0] COOL_LOAD = CCW'(COOLDOWN_CYCLES);

  // Three-bit encoding leaves spare codes; any of them falls back to IDLE.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_READY = 3'd1,
    S_HOLD       = 3'd2,
    S_COOLDOWN   = 3'd3
  } state_t;

  state_t         state_reg, state_next;
  logic [HCW-1:0] hold_cnt_reg, hold_cnt_next;
  logic [CCW-1:0] cool_cnt_reg, cool_cnt_next;
  logic           t1_reg, t1_next;
  logic           t2_reg, t2_next;
  logic           t3_reg, t3_next;
  logic           t4_reg, t4_next;
  logic           forced_reg, forced_next;
  logic           busy_reg;
  logic           limit_hit;

  // The limit only counts as reached on a cycle where the grant is really held.
  assign limit_hit = i_granted && (hold_cnt_reg == HOLD_LAST);

  // Next-state, counter and pulse decode; at most one pulse per cycle by construction.
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    cool_cnt_next = cool_cnt_reg;
    t1_next       = 1'b0;
    t2_next       = 1'b0;
    t3_next       = 1'b0;
    t4_next       = 1'b0;
    forced_next   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (i_req) begin
          t1_next    = 1'b1;
          state_next = S_WAIT_READY;
        end
      end
      S_WAIT_READY: begin
        // A dropped i_req does not abandon the sequence here.
        if (i_ready) begin
          t2_next       = 1'b1;
          hold_cnt_next = '0;
          state_next    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_done || limit_hit) begin
          t3_next       = 1'b1;
          forced_next   = limit_hit && !i_done;
          cool_cnt_next = COOL_LOAD;
          state_next    = S_COOLDOWN;
        end else if (i_granted) begin
          hold_cnt_next = hold_cnt_reg + HCW'(1);
        end
      end
      S_COOLDOWN: begin
        if (cool_cnt_reg == '0) begin
          t4_next    = 1'b1;
          state_next = S_IDLE;
        end else begin
          cool_cnt_next = cool_cnt_reg - CCW'(1);
        end
      end
      default: begin
        state_next    = S_IDLE;
        hold_cnt_next = '0;
        cool_cnt_next = '0;
      end
    endcase
  end

  // State, counters and all outputs registered together; reset aborts everything.
  always_ff @(posedge i_ck or posedge i_arst) begin
    if (i_arst) begin
      state_reg    <= S_IDLE;
      hold_cnt_reg <= '0;
      cool_cnt_reg <= '0;
      t1_reg       <= 1'b0;
      t2_reg       <= 1'b0;
      t3_reg       <= 1'b0;
      t4_reg       <= 1'b0;
      forced_reg   <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      cool_cnt_reg <= cool_cnt_next;
      t1_reg       <= t1_next;
      t2_reg       <= t2_next;
      t3_reg       <= t3_next;
      t4_reg       <= t4_next;
      forced_reg   <= forced_next;
      busy_reg     <= (state_next != S_IDLE);
    end
  end

  assign o_stateTransition1 = t1_reg;
  assign o_stateTransition2 = t2_reg;
  assign o_stateTransition3 = t3_reg;
  assign o_stateTransition4 = t4_reg;
  assign o_forcedRevoke     = forced_reg;
  assign o_busy             = busy_reg;

`ifdef GRANT_REQ_SEQ_STATS_EN
  logic [STAT_W-1:0] grant_cnt_reg;
  logic [STAT_W-1:0] forced_cnt_reg;

  // Saturating statistics; they count the visible pulses and a clear beats an increment.
  always_ff @(posedge i_ck or posedge i_arst) begin
    if (i_arst) begin
      grant_cnt_reg  <= '0;
      forced_cnt_reg <= '0;
    end else if (i_statClr) begin
      grant_cnt_reg  <= '0;
      forced_cnt_reg <= '0;
    end else begin
      if (t2_reg && (grant_cnt_reg != '1))
        grant_cnt_reg <= grant_cnt_reg + STAT_W'(1);
      if (forced_reg && (forced_cnt_reg != '1))
        forced_cnt_reg <= forced_cnt_reg + STAT_W'(1);
    end
  end

  assign o_grantCount  = grant_cnt_reg;
  assign o_forcedCount = forced_cnt_reg;
`endif

endmodule

// File: tb/tb_grant_request_sequencer.sv
// Testbench for grant_request_sequencer.
// Two instances: dut_a with default parameters (MAX=16, COOLDOWN=2) and
// dut_b with MAX=4, COOLDOWN=0, STAT_W=2. The instance not under test is
// held in reset. Each step drives one cycle of inputs, queues the output
// vector expected in the following cycle, then pops and compares it.
// Output vector layout: {t1, t2, t3, t4, forced, busy}.
module tb_grant_request_sequencer;

  localparam logic [5:0] Z   = 6'b000000;
  localparam logic [5:0] B   = 6'b000001;
  localparam logic [5:0] P1  = 6'b100001;
  localparam logic [5:0] P2  = 6'b010001;
  localparam logic [5:0] P3  = 6'b001001;
  localparam logic [5:0] P3F = 6'b001011;
  localparam logic [5:0] P4  = 6'b000100;

  logic clk = 1'b0;
  logic arst_a, arst_b;
  logic req, ready, done, granted;
  logic stat_clr;
  logic sel;

  logic a_t1, a_t2, a_t3, a_t4, a_f, a_busy;
  logic b_t1, b_t2, b_t3, b_t4, b_f, b_busy;
  logic [5:0] obs_a, obs_b;

`ifdef GRANT_REQ_SEQ_STATS_EN
  logic [15:0] a_gcnt, a_fcnt;
  logic [1:0]  b_gcnt, b_fcnt;
`endif

  int n_checks = 0;
  int n_err    = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  assign obs_a = {a_t1, a_t2, a_t3, a_t4, a_f, a_busy};
  assign obs_b = {b_t1, b_t2, b_t3, b_t4, b_f, b_busy};

  grant_request_sequencer dut_a (
    .i_ck(clk), .i_arst(arst_a), .i_req(req), .i_ready(ready),
    .i_done(done), .i_granted(granted),
`ifdef GRANT_REQ_SEQ_STATS_EN
    .i_statClr(stat_clr), .o_grantCount(a_gcnt), .o_forcedCount(a_fcnt),
`endif
    .o_stateTransition1(a_t1), .o_stateTransition2(a_t2),
    .o_stateTransition3(a_t3), .o_stateTransition4(a_t4),
    .o_forcedRevoke(a_f), .o_busy(a_busy)
  );

  grant_request_sequencer #(
    .MAX_GRANT_CYCLES(4), .COOLDOWN_CYCLES(0), .STAT_W(2)
  ) dut_b (
    .i_ck(clk), .i_arst(arst_b), .i_req(req), .i_ready(ready),
    .i_done(done), .i_granted(granted),
`ifdef GRANT_REQ_SEQ_STATS_EN
    .i_statClr(stat_clr), .o_grantCount(b_gcnt), .o_forcedCount(b_fcnt),
`endif
    .o_stateTransition1(b_t1), .o_stateTransition2(b_t2),
    .o_stateTransition3(b_t3), .o_stateTransition4(b_t4),
    .o_forcedRevoke(b_f), .o_busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic d, input logic g,
                      input logic [5:0] e, input string tag);
    logic [5:0] exp_v;
    req = r; ready = rd; done = d; granted = g;
    exp_q.push_back(e);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    chk(tag, sel ? obs_b : obs_a, exp_v);
    $display("step %s: out=%06b exp=%06b", tag, sel ? obs_b : obs_a, exp_v);
  endtask

`ifdef GRANT_REQ_SEQ_STATS_EN
  task automatic run_seq(input logic forced);
    step(1, 0, 0, 0, P1, "st_p1");
    step(0, 1, 0, 0, P2, "st_p2");
    if (forced) begin
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, B, "st_hold");
      step(0, 0, 0, 1, P3F, "st_p3f");
    end else begin
      step(0, 0, 1, 0, P3, "st_p3");
    end
    step(0, 0, 0, 0, P4, "st_p4");
    step(0, 0, 0, 0, Z, "st_idle");
  endtask
`endif

  initial begin
    arst_a = 1'b1; arst_b = 1'b1;
    req = 0; ready = 0; done = 0; granted = 0; stat_clr = 0; sel = 0;
    #12;
    chk("reset_a", obs_a, Z);
    chk("reset_b", obs_b, Z);
    @(posedge clk); #1;
    arst_a = 1'b0;

    // Reset mid-HOLD: build hold count to 5, then abort.
    step(1, 0, 0, 0, P1, "rh_p1");
    step(0, 1, 0, 0, P2, "rh_p2");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, B, "rh_hold");
    arst_a = 1'b1;
    #1;
    chk("rh_async", obs_a, Z);
    step(0, 0, 1, 1, Z, "rh_inrst");
    step(0, 0, 1, 1, Z, "rh_inrst");
    arst_a = 1'b0;
    step(0, 0, 1, 1, Z, "rh_idle");
    step(0, 0, 1, 1, Z, "rh_idle");

    // Normal sequence: step k drives cycle k, checks cycle k+1.
    step(1, 0, 0, 0, P1, "n_c1");
    step(0, 0, 0, 0, B,  "n_c2");
    step(0, 0, 0, 0, B,  "n_c3");
    step(0, 1, 0, 0, P2, "n_c4");
    step(0, 0, 0, 0, B,  "n_c5");
    step(0, 0, 0, 0, B,  "n_c6");
    step(0, 0, 0, 1, B,  "n_c7");
    step(0, 0, 0, 1, B,  "n_c8");
    step(0, 0, 0, 1, B,  "n_c9");
    step(0, 0, 1, 1, P3, "n_c10");
    step(0, 0, 0, 0, B,  "n_c11");
    step(0, 0, 0, 0, B,  "n_c12");
    step(0, 0, 0, 0, P4, "n_c13");
    step(0, 0, 0, 0, Z,  "n_c14");

    // Switch to dut_b (MAX=4, COOLDOWN=0).
    arst_a = 1'b1; arst_b = 1'b0; sel = 1'b1;
    step(0, 0, 0, 0, Z, "b_idle");

    // Forced revoke on the 4th granted cycle.
    step(1, 0, 0, 0, P1,  "f_p1");
    step(0, 1, 0, 0, P2,  "f_p2");
    step(0, 0, 0, 1, B,   "f_g1");
    step(0, 0, 0, 1, B,   "f_g2");
    step(0, 0, 0, 1, B,   "f_g3");
    step(0, 0, 0, 1, P3F, "f_g4");
    step(0, 0, 0, 0, P4,  "f_p4");
    step(0, 0, 0, 0, Z,   "f_idle");

    // Grant gaps with i_req held high; cooldown 0 re-requests right after.
    step(1, 0, 0, 0, P1,  "g_p1");
    step(1, 1, 0, 0, P2,  "g_p2");
    step(1, 0, 0, 1, B,   "g_h1");
    step(1, 0, 0, 0, B,   "g_l1");
    step(1, 0, 0, 1, B,   "g_h2");
    step(1, 0, 0, 0, B,   "g_l2");
    step(1, 0, 0, 1, B,   "g_h3");
    step(1, 0, 0, 0, B,   "g_l3");
    step(1, 0, 0, 1, P3F, "g_h4");
    step(1, 0, 0, 0, P4,  "g_p4");
    step(1, 0, 0, 0, P1,  "g_rep1");

    // Done coincides with the limit: ordinary revoke.
    step(0, 1, 0, 0, P2, "c_p2");
    step(0, 0, 0, 1, B,  "c_g1");
    step(0, 0, 0, 1, B,  "c_g2");
    step(0, 0, 0, 1, B,  "c_g3");
    step(0, 0, 1, 1, P3, "c_g4done");
    step(0, 0, 0, 0, P4, "c_p4");
    step(0, 0, 0, 0, Z,  "c_idle");

`ifdef GRANT_REQ_SEQ_STATS_EN
    stat_clr = 1'b1;
    step(0, 0, 0, 0, Z, "s_clr");
    stat_clr = 1'b0;
    chk("s_gcnt0", 32'(b_gcnt), 0);
    chk("s_fcnt0", 32'(b_fcnt), 0);
    for (int i = 0; i < 5; i++) run_seq(i < 2);
    chk("s_gcnt_sat", 32'(b_gcnt), 3);
    chk("s_fcnt", 32'(b_fcnt), 2);
    step(1, 0, 0, 0, P1, "s_p1");
    step(0, 1, 0, 0, P2, "s_p2");
    stat_clr = 1'b1;
    step(0, 0, 1, 0, P3, "s_p3clr");
    stat_clr = 1'b0;
    chk("s_gcnt_clrwin", 32'(b_gcnt), 0);
    chk("s_fcnt_clr", 32'(b_fcnt), 0);
    step(0, 0, 0, 0, P4, "s_p4");
    step(0, 0, 0, 0, Z,  "s_idle");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/grant_request_sequencer.md
Name: grant_request_sequencer

Overview:
Upstream stage that drives the four transition inputs of the IDLE/REQUESTING/GRANT/REVOKE arbitration FSM. It turns a requester's level handshake (req/done) and a resource-ready signal into single-cycle transition pulses. It enforces a maximum grant length and a post-revoke cooldown. The FSM's grant indicator is fed back so that grant time is counted only while the grant is actually held.

Parameters:
MAX_GRANT_CYCLES, 16, maximum number of cycles i_granted may be high before a forced revoke; legal range >= 1.
COOLDOWN_CYCLES, 2, idle cycles spent in COOLDOWN before the IDLE-return pulse; legal range >= 0.
STAT_W, 16, width of the statistics counters (optional feature only).

Ports:
i_ck  input  1  clock, rising edge.
i_arst  input  1  reset, asynchronous, active-high.
i_req  input  1  requester wants the resource (level).
i_ready  input  1  resource available (level).
i_done  input  1  requester finished; sampled only in HOLD.
i_granted  input  1  grant indicator fed back from the downstream FSM.
o_stateTransition1  output  1  pulse: IDLE->REQUESTING.
o_stateTransition2  output  1  pulse: REQUESTING->GRANT.
o_stateTransition3  output  1  pulse: GRANT->REVOKE.
o_stateTransition4  output  1  pulse: REVOKE->IDLE.
o_forcedRevoke  output  1  one-cycle pulse, coincident with o_stateTransition3 when the revoke was caused by the limit.
o_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered. On i_arst: state IDLE, all counters 0, all outputs 0. An assertion mid-operation aborts immediately; no pulses are issued for the aborted sequence.
- Each transition pulse lasts exactly one cycle. At most one transition pulse is high in any cycle.
- States:
  - IDLE: if i_req=1, register o_stateTransition1=1 and go to WAIT_READY.
  - WAIT_READY: if i_ready=1, register o_stateTransition2=1, clear the hold counter and go to HOLD. A deasserted i_req does not abandon the sequence; the block keeps waiting for i_ready.
  - HOLD:
    - The hold counter increments on every cycle with i_granted=1. Its width is clog2(MAX_GRANT_CYCLES+1).
    - Cycles with i_granted=0 (pipeline latency of the FSM) are not counted.
    - Revoke when i_done=1, or when i_granted=1 and the counter equals MAX_GRANT_CYCLES-1. On revoke: o_stateTransition3=1, load the cooldown counter, go to COOLDOWN.
    - If the revoke is limit-caused and i_done is not asserted in that cycle, o_forcedRevoke=1 in the same cycle as o_stateTransition3. If i_done and the limit coincide, the revoke is treated as normal (no forced pulse).
  - COOLDOWN: the counter counts down from COOLDOWN_CYCLES. When it reaches 0, o_stateTransition4=1 and go to IDLE. With COOLDOWN_CYCLES=0, o_stateTransition4 fires on the first cycle in COOLDOWN.
- Returning to IDLE with i_req still high starts a new sequence on the next cycle. There is no back-to-back pulse in the same cycle as o_stateTransition4.
- Latency, IDLE to o_stateTransition1: i_req high in cycle N gives the pulse in cycle N+1.
- Unreachable state encodings recover to IDLE with no pulses.
- o_busy = (state != IDLE), registered together with the state.

Optional Feature:
- GRANT_REQ_SEQ_STATS_EN defined:
  - Adds outputs o_grantCount and o_forcedCount, both STAT_W wide.
  - o_grantCount increments on each o_stateTransition2; o_forcedCount increments on each o_forcedRevoke.
  - Both saturate at all-ones and reset to 0 on i_arst.
  - Adds input i_statClr, synchronous: clears both counters. If a clear and an increment occur in the same cycle, the clear wins.
- Not defined: these ports and counters do not exist, and core behaviour is identical.

Test Plan:
- Reset mid-HOLD: assert i_arst with counter=5 -> all outputs 0 immediately; IDLE after release; no o_stateTransition3/4 issued.
- Normal sequence: i_req=1 at cycle 0, i_ready=1 at cycle 3, i_granted high from cycle 6, i_done=1 at cycle 9 -> pulses at cycles 1, 4, 10, then o_stateTransition4 at cycle 13 (COOLDOWN_CYCLES=2); o_forcedRevoke stays 0.
- Forced revoke: MAX_GRANT_CYCLES=4, i_done held 0, i_granted high -> o_stateTransition3 and o_forcedRevoke pulse together on the 4th granted cycle; i_done and the limit in the same cycle -> o_forcedRevoke=0.
- Grant gaps: i_granted toggles 1,0,1,0,... with MAX=4 -> revoke occurs after the 4th high cycle, not after 4 wall-clock cycles.
- COOLDOWN_CYCLES=0 with i_req held high -> o_stateTransition4 one cycle after o_stateTransition3, o_stateTransition1 the following cycle, never two pulses in one cycle.
- GRANT_REQ_SEQ_STATS_EN with STAT_W=2: 5 grants (2 forced) -> o_grantCount=3 (saturated), o_forcedCount=2; i_statClr pulsed in the same cycle as a grant -> o_grantCount=0.
